// File: rtl/mole_spawner_if.sv
// Signal bundle between the random generator / game controller (master)
// and the mole spawner (slave).
interface mole_spawner_if #(
    parameter int NUM_HOLES = 9
);
    logic [8:0]           rand_num;
    logic                 tick_ms;
    logic                 spawn_req;
    logic                 hit_valid;
    logic [3:0]           hit_hole;
    logic [NUM_HOLES-1:0] mole_mask;
    logic                 spawn_ack;
    logic [3:0]           spawn_hole;
    logic                 spawn_drop;
    logic                 hit_ok;
    logic                 hit_bad;
    logic [NUM_HOLES-1:0] expire_mask;
    logic                 busy;

    modport master (
        output rand_num, tick_ms, spawn_req, hit_valid, hit_hole,
        input  mole_mask, spawn_ack, spawn_hole, spawn_drop, hit_ok, hit_bad,
               expire_mask, busy
    );

    modport slave (
        input  rand_num, tick_ms, spawn_req, hit_valid, hit_hole,
        output mole_mask, spawn_ack, spawn_hole, spawn_drop, hit_ok, hit_bad,
               expire_mask, busy
    );
endinterface

// File: rtl/mole_spawner.sv
// Turns raw random words into mole placements (rejection-sampled hole plus
// random lifetime), ages live moles on the ms tick and resolves player hits.
module mole_spawner #(
    parameter int NUM_HOLES  = 9,
    parameter int MAX_ACTIVE = 3,
    parameter int LIFE_BASE  = 500,
    parameter int RETRY_MAX  = 16
) (
    input  logic          clk_1mhz,
    input  logic          rst,
    mole_spawner_if.slave bus
);
    localparam int RETRY_W = $clog2(RETRY_MAX + 1);

    typedef enum logic [0:0] {IDLE, SAMPLE} state_t;

    state_t             state;
    logic [RETRY_W-1:0] retry;
    logic [9:0]         life_cnt [NUM_HOLES];

    logic [15:0]          mask_ext;
    logic [15:0]          free_ext;
    logic [NUM_HOLES-1:0] hit_clear;
    logic [NUM_HOLES-1:0] expire_now;
    logic [NUM_HOLES-1:0] live_after;
    logic [NUM_HOLES-1:0] free_mask;
    logic [NUM_HOLES-1:0] place_bit;
    logic                 hit_live;
    logic                 cand_ok;
    logic                 place;
    logic                 at_capacity;
    logic [3:0]           cand;
    logic [3:0]           fb_hole;
    logic [3:0]           place_hole;
    logic [9:0]           place_life;

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path can leave it holding a value (no latch).
    always_comb begin
        hit_clear  = '0;
        expire_now = '0;
        place_bit  = '0;
        fb_hole    = '0;

        // Zero padding above NUM_HOLES makes out-of-range indices read as empty.
        mask_ext = 16'(bus.mole_mask);
        hit_live = bus.hit_valid && mask_ext[bus.hit_hole];

        for (int i = 0; i < NUM_HOLES; i++) begin
            hit_clear[i]  = hit_live && (bus.hit_hole == 4'(i));
            expire_now[i] = bus.tick_ms && bus.mole_mask[i] &&
                            (life_cnt[i] == 10'd1) && !hit_clear[i];
        end

        live_after = bus.mole_mask & ~hit_clear & ~expire_now;
        free_mask  = ~live_after;
        free_ext   = 16'(free_mask);

        cand    = bus.rand_num[3:0];
        cand_ok = free_ext[cand];
        for (int i = NUM_HOLES - 1; i >= 0; i--) begin
            if (free_mask[i]) fb_hole = 4'(i);
        end

        place      = (state == SAMPLE) &&
                     (cand_ok || (retry == RETRY_W'(RETRY_MAX - 1)));
        place_hole = cand_ok ? cand : fb_hole;
        place_life = cand_ok ? 10'(LIFE_BASE) + 10'(bus.rand_num[8:4])
                             : 10'(LIFE_BASE);
        for (int i = 0; i < NUM_HOLES; i++) begin
            place_bit[i] = place && (place_hole == 4'(i));
        end

        at_capacity = ($countones(bus.mole_mask) == MAX_ACTIVE);
    end

    // NOTE: the lifetime counters are a small flop array, not RAM, so they
    // take the asynchronous reset together with the rest of the state.
    always_ff @(posedge clk_1mhz or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            retry           <= '0;
            bus.mole_mask   <= '0;
            bus.spawn_ack   <= 1'b0;
            bus.spawn_hole  <= '0;
            bus.spawn_drop  <= 1'b0;
            bus.hit_ok      <= 1'b0;
            bus.hit_bad     <= 1'b0;
            bus.expire_mask <= '0;
            bus.busy        <= 1'b0;
            for (int i = 0; i < NUM_HOLES; i++) life_cnt[i] <= '0;
        end else begin
            bus.spawn_ack   <= place;
            bus.spawn_drop  <= 1'b0;
            bus.hit_ok      <= hit_live;
            bus.hit_bad     <= bus.hit_valid && !hit_live;
            bus.expire_mask <= expire_now;
            bus.mole_mask   <= live_after | place_bit;
            if (place) bus.spawn_hole <= place_hole;

            // A placement overrides a same-cycle clear of a freed hole.
            for (int i = 0; i < NUM_HOLES; i++) begin
                if (place_bit[i])
                    life_cnt[i] <= place_life;
                else if (hit_clear[i] || expire_now[i])
                    life_cnt[i] <= '0;
                else if (bus.tick_ms && bus.mole_mask[i])
                    life_cnt[i] <= life_cnt[i] - 10'd1;
            end

            unique case (state)
                IDLE: begin
                    if (bus.spawn_req) begin
                        if (at_capacity) begin
                            bus.spawn_drop <= 1'b1;
                        end else begin
                            state    <= SAMPLE;
                            retry    <= '0;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                SAMPLE: begin
                    bus.spawn_drop <= bus.spawn_req;
                    if (place) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        retry <= retry + RETRY_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mole_spawner.sv
// Self-checking bench for mole_spawner: directed scenarios plus a randomized
// run compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_mole_spawner;
    localparam int NH = 9;
    localparam int MA = 3;
    localparam int LB = 500;
    localparam int RM = 16;

    logic clk_1mhz = 1'b0;
    logic rst;

    mole_spawner_if #(.NUM_HOLES(NH)) bus ();

    mole_spawner #(
        .NUM_HOLES (NH),
        .MAX_ACTIVE(MA),
        .LIFE_BASE (LB),
        .RETRY_MAX (RM)
    ) dut (
        .clk_1mhz(clk_1mhz),
        .rst     (rst),
        .bus     (bus)
    );

    always #500 clk_1mhz = ~clk_1mhz;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model: per-hole alive flag and remaining lifetime in ms.
    bit      m_live [NH];
    int      m_life [NH];
    bit      m_sampling;
    int      m_tries;
    logic [NH-1:0] e_mask, e_expire;
    logic          e_ack, e_drop, e_ok, e_bad, e_busy;
    logic [3:0]    e_hole;

    function automatic logic [26:0] dut_vec();
        return {bus.mole_mask, bus.expire_mask, bus.spawn_hole, bus.spawn_ack,
                bus.spawn_drop, bus.hit_ok, bus.hit_bad, bus.busy};
    endfunction

    function automatic logic [26:0] exp_vec();
        return {e_mask, e_expire, e_hole, e_ack, e_drop, e_ok, e_bad, e_busy};
    endfunction

    task automatic model_reset();
        for (int h = 0; h < NH; h++) begin
            m_live[h] = 1'b0;
            m_life[h] = 0;
        end
        m_sampling = 1'b0;
        m_tries    = 0;
        e_mask = '0; e_expire = '0; e_hole = '0;
        e_ack = 1'b0; e_drop = 1'b0; e_ok = 1'b0; e_bad = 1'b0; e_busy = 1'b0;
    endtask

    // Advances the model by one clock edge given the inputs seen at that edge.
    task automatic model_step(input bit req, input bit tick, input bit hv,
                              input int hh, input int rn);
        int live_cnt = 0;
        int cand;
        int place_h = -1;
        int place_l = 0;
        e_ack = 1'b0; e_drop = 1'b0; e_ok = 1'b0; e_bad = 1'b0; e_expire = '0;
        for (int h = 0; h < NH; h++) live_cnt += int'(m_live[h]);

        if (hv) begin
            if (hh < NH && m_live[hh]) begin
                e_ok = 1'b1;
                m_live[hh] = 1'b0;
                m_life[hh] = 0;
            end else begin
                e_bad = 1'b1;
            end
        end

        if (tick) begin
            for (int h = 0; h < NH; h++) begin
                if (m_live[h]) begin
                    if (m_life[h] == 1) begin
                        m_live[h]   = 1'b0;
                        m_life[h]   = 0;
                        e_expire[h] = 1'b1;
                    end else begin
                        m_life[h] = m_life[h] - 1;
                    end
                end
            end
        end

        if (!m_sampling) begin
            if (req) begin
                if (live_cnt == MA) e_drop = 1'b1;
                else begin
                    m_sampling = 1'b1;
                    m_tries    = 0;
                end
            end
        end else begin
            e_drop = req;
            cand   = rn % 16;
            if (cand < NH && !m_live[cand]) begin
                place_h = cand;
                place_l = LB + rn / 16;
            end else if (m_tries == RM - 1) begin
                for (int h = NH - 1; h >= 0; h--) if (!m_live[h]) place_h = h;
                place_l = LB;
            end else begin
                m_tries++;
            end
            if (place_h >= 0) begin
                m_live[place_h] = 1'b1;
                m_life[place_h] = place_l;
                e_ack      = 1'b1;
                e_hole     = 4'(place_h);
                m_sampling = 1'b0;
            end
        end
        e_busy = m_sampling;
        for (int h = 0; h < NH; h++) e_mask[h] = m_live[h];
    endtask

    task automatic step(input bit req, input bit tick, input bit hv,
                        input int hh, input int rn);
        bus.spawn_req = req;
        bus.tick_ms   = tick;
        bus.hit_valid = hv;
        bus.hit_hole  = 4'(hh);
        bus.rand_num  = 9'(rn);
        model_step(req, tick, hv, hh, rn);
        @(posedge clk_1mhz);
        #1;
    endtask

    task automatic spawn_at(input int rn);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, rn);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 0, int'($urandom_range(0, 511)));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.spawn_req = 1'b0; bus.tick_ms = 1'b0; bus.hit_valid = 1'b0;
        bus.hit_hole = '0; bus.rand_num = '0;
        model_reset();
        repeat (2) @(posedge clk_1mhz);
        #1;
        tests_run++;
        if (dut_vec() !== 27'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0", dut_vec());
        end
        rst = 1'b0;
    endtask

    task automatic test_first_spawn();
        step(1'b1, 1'b0, 1'b0, 0, 0);
        tests_run++;
        if (bus.busy !== 1'b1 || bus.spawn_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL spawn_enter_sample: busy=%b ack=%b expected busy=1 ack=0", bus.busy, bus.spawn_ack);
        end
        step(1'b0, 1'b0, 1'b0, 0, 'h1F4);
        tests_run++;
        if (bus.spawn_ack !== 1'b1 || bus.spawn_hole !== 4'd4 || bus.mole_mask !== 9'h010 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_spawn: ack=%b hole=%0d mask=%h busy=%b expected 1/4/010/0",
                     bus.spawn_ack, bus.spawn_hole, bus.mole_mask, bus.busy);
        end
        step(1'b0, 1'b0, 1'b0, 0, 0);
        tests_run++;
        if (bus.spawn_ack !== 1'b0 || bus.spawn_hole !== 4'd4) begin
            tests_failed++;
            $display("FAIL ack_pulse_hold: ack=%b hole=%0d expected 0/4", bus.spawn_ack, bus.spawn_hole);
        end
    endtask

    task automatic test_expiry();
        ticks(530);
        tests_run++;
        if (bus.mole_mask !== 9'h010 || bus.expire_mask !== 9'h000) begin
            tests_failed++;
            $display("FAIL expiry_early: mask=%h expire=%h expected 010/000", bus.mole_mask, bus.expire_mask);
        end
        ticks(1);
        tests_run++;
        if (bus.expire_mask !== 9'h010 || bus.mole_mask !== 9'h000) begin
            tests_failed++;
            $display("FAIL expiry_531: expire=%h mask=%h expected 010/000", bus.expire_mask, bus.mole_mask);
        end
        step(1'b0, 1'b0, 1'b0, 0, 0);
        tests_run++;
        if (bus.expire_mask !== 9'h000) begin
            tests_failed++;
            $display("FAIL expiry_pulse: expire=%h expected 000", bus.expire_mask);
        end
    endtask

    task automatic test_rejection();
        int seq [4] = '{12, 15, 4, 9};
        bit early_ack = 1'b0;
        spawn_at('h004);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        foreach (seq[i]) begin
            step(1'b0, 1'b0, 1'b0, 0, int'($urandom_range(0, 31)) * 16 + seq[i]);
            if (bus.spawn_ack !== 1'b0 || bus.busy !== 1'b1) early_ack = 1'b1;
        end
        tests_run++;
        if (early_ack) begin
            tests_failed++;
            $display("FAIL reject_seq: ack or busy wrong during rejected candidates, expected ack=0 busy=1");
        end
        step(1'b0, 1'b0, 1'b0, 0, int'($urandom_range(0, 31)) * 16 + 2);
        tests_run++;
        if (bus.spawn_ack !== 1'b1 || bus.spawn_hole !== 4'd2 || bus.mole_mask !== 9'h014) begin
            tests_failed++;
            $display("FAIL reject_accept: ack=%b hole=%0d mask=%h expected 1/2/014",
                     bus.spawn_ack, bus.spawn_hole, bus.mole_mask);
        end

        early_ack = 1'b0;
        step(1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < RM - 1; i++) begin
            step(1'b0, 1'b0, 1'b0, 0, int'($urandom_range(0, 31)) * 16 + 15);
            if (bus.spawn_ack !== 1'b0) early_ack = 1'b1;
        end
        tests_run++;
        if (early_ack) begin
            tests_failed++;
            $display("FAIL fallback_early: ack seen before %0d sampling cycles", RM);
        end
        step(1'b0, 1'b0, 1'b0, 0, 'h1FF);
        tests_run++;
        if (bus.spawn_ack !== 1'b1 || bus.spawn_hole !== 4'd0 || bus.mole_mask !== 9'h015) begin
            tests_failed++;
            $display("FAIL fallback: ack=%b hole=%0d mask=%h expected 1/0/015",
                     bus.spawn_ack, bus.spawn_hole, bus.mole_mask);
        end
    endtask

    task automatic test_capacity();
        step(1'b1, 1'b0, 1'b0, 0, 'h003);
        tests_run++;
        if (bus.spawn_drop !== 1'b1 || bus.mole_mask !== 9'h015 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL capacity_drop: drop=%b mask=%h busy=%b expected 1/015/0",
                     bus.spawn_drop, bus.mole_mask, bus.busy);
        end
    endtask

    task automatic test_hits();
        step(1'b0, 1'b0, 1'b1, 2, 0);
        tests_run++;
        if (bus.hit_ok !== 1'b1 || bus.hit_bad !== 1'b0 || bus.mole_mask !== 9'h011) begin
            tests_failed++;
            $display("FAIL hit_live: ok=%b bad=%b mask=%h expected 1/0/011", bus.hit_ok, bus.hit_bad, bus.mole_mask);
        end
        step(1'b0, 1'b0, 1'b1, 7, 0);
        tests_run++;
        if (bus.hit_ok !== 1'b0 || bus.hit_bad !== 1'b1 || bus.mole_mask !== 9'h011) begin
            tests_failed++;
            $display("FAIL hit_empty: ok=%b bad=%b mask=%h expected 0/1/011", bus.hit_ok, bus.hit_bad, bus.mole_mask);
        end
        step(1'b0, 1'b0, 1'b1, 12, 0);
        tests_run++;
        if (bus.hit_ok !== 1'b0 || bus.hit_bad !== 1'b1 || bus.mole_mask !== 9'h011) begin
            tests_failed++;
            $display("FAIL hit_range: ok=%b bad=%b mask=%h expected 0/1/011", bus.hit_ok, bus.hit_bad, bus.mole_mask);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 'h00F);
        tests_run++;
        if (bus.spawn_drop !== 1'b1 || bus.busy !== 1'b1 || bus.spawn_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_drop: drop=%b busy=%b ack=%b expected 1/1/0", bus.spawn_drop, bus.busy, bus.spawn_ack);
        end
        step(1'b0, 1'b0, 1'b0, 0, 'h013);
        tests_run++;
        if (bus.spawn_ack !== 1'b1 || bus.spawn_hole !== 4'd3 || bus.mole_mask !== 9'h019 || bus.spawn_drop !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_complete: ack=%b hole=%0d mask=%h drop=%b expected 1/3/019/0",
                     bus.spawn_ack, bus.spawn_hole, bus.mole_mask, bus.spawn_drop);
        end
    endtask

    task automatic test_multi_expiry();
        ticks(499);
        tests_run++;
        if (bus.expire_mask !== 9'h000 || bus.mole_mask !== 9'h019) begin
            tests_failed++;
            $display("FAIL multi_expiry_early: expire=%h mask=%h expected 000/019", bus.expire_mask, bus.mole_mask);
        end
        ticks(1);
        tests_run++;
        if (bus.expire_mask !== 9'h011 || bus.mole_mask !== 9'h008) begin
            tests_failed++;
            $display("FAIL multi_expiry: expire=%h mask=%h expected 011/008", bus.expire_mask, bus.mole_mask);
        end
        ticks(1);
        tests_run++;
        if (bus.expire_mask !== 9'h008 || bus.mole_mask !== 9'h000) begin
            tests_failed++;
            $display("FAIL late_expiry: expire=%h mask=%h expected 008/000", bus.expire_mask, bus.mole_mask);
        end
    endtask

    task automatic test_hit_final_tick();
        spawn_at('h007);
        ticks(499);
        step(1'b0, 1'b1, 1'b1, 7, 0);
        tests_run++;
        if (bus.hit_ok !== 1'b1 || bus.expire_mask !== 9'h000 || bus.mole_mask !== 9'h000) begin
            tests_failed++;
            $display("FAIL hit_vs_expiry: ok=%b expire=%h mask=%h expected 1/000/000",
                     bus.hit_ok, bus.expire_mask, bus.mole_mask);
        end
    endtask

    task automatic test_reset_mid_sample();
        spawn_at('h001);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        bus.spawn_req = 1'b0; bus.tick_ms = 1'b0; bus.hit_valid = 1'b0;
        bus.hit_hole = '0; bus.rand_num = '0;
        #100 rst = 1'b1;
        #10;
        model_reset();
        tests_run++;
        if (dut_vec() !== 27'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_sample: got %h expected 0", dut_vec());
        end
        @(posedge clk_1mhz);
        #1 rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 0, 0);
        tests_run++;
        if (bus.spawn_ack !== 1'b0 || bus.spawn_drop !== 1'b0 || bus.mole_mask !== 9'h000 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_abort: ack=%b drop=%b mask=%h busy=%b expected all 0",
                     bus.spawn_ack, bus.spawn_drop, bus.mole_mask, bus.busy);
        end
        spawn_at('h0A5);
        tests_run++;
        if (bus.spawn_ack !== 1'b1 || bus.spawn_hole !== 4'd5 || bus.mole_mask !== 9'h020) begin
            tests_failed++;
            $display("FAIL spawn_after_reset: ack=%b hole=%0d mask=%h expected 1/5/020",
                     bus.spawn_ack, bus.spawn_hole, bus.mole_mask);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 511)));
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL random_cycle_%0d: got mask=%h exp=%h hole=%0d ack=%b drop=%b ok=%b bad=%b busy=%b, expected mask=%h exp=%h hole=%0d ack=%b drop=%b ok=%b bad=%b busy=%b",
                         i, bus.mole_mask, bus.expire_mask, bus.spawn_hole, bus.spawn_ack, bus.spawn_drop,
                         bus.hit_ok, bus.hit_bad, bus.busy,
                         e_mask, e_expire, e_hole, e_ack, e_drop, e_ok, e_bad, e_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_expiry();
        test_rejection();
        test_capacity();
        test_hits();
        test_back_to_back();
        test_multi_expiry();
        test_hit_final_tick();
        test_reset_mid_sample();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
